gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_PATTERNS, 256, patterns per run; legal range 1..65535.
- SETTLE, 2, wait cycles between apply and capture; legal range 1..15.
- SEED, 17'h1ACE1, LFSR seed after reset; must be nonzero.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a run; sampled in IDLE only.
- abort, in, 1, terminate a run.
- seed_load, in, 1, capture seed into seed_reg; honoured in IDLE only.
- seed, in, 17, new LFSR seed.
- dut_in, out, 17, registered stimulus to the 17-input gate model; bit0 drives N1, bit16 drives N17.
- dut_out, in, 10, gate model response in order {N517,N516,N515,N514,N513,N512,N510,N509,N505,N504}; bit0 = N504.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at run completion.
- signature, out, 10, MISR contents; held stable while not busy.
- pattern_cnt, out, 16, patterns captured in the current or last run.
REQ-003 One clock domain and one asynchronous active-low reset (rst_n) SHALL be used; there SHALL be no other clocks or resets.

Function
REQ-004 The FSM SHALL have the states IDLE, APPLY, SETTLE, CAPTURE and DONE, encoded in 3 bits.
REQ-005 In IDLE, start=1 SHALL load lfsr<=seed_reg, clear MISR and pattern_cnt, and move to APPLY; otherwise the FSM stays in IDLE.
REQ-006 In APPLY, the block SHALL register dut_in<=lfsr, load settle_cnt<=SETTLE-1, and move to SETTLE.
REQ-007 In SETTLE, the block SHALL decrement settle_cnt and move to CAPTURE in the cycle settle_cnt==0, so it spends exactly SETTLE cycles in SETTLE.
REQ-008 In CAPTURE, the block SHALL update the MISR and advance the LFSR and pattern_cnt+1 in the same cycle. It SHALL then move to DONE if the new pattern_cnt==NUM_PATTERNS, otherwise to APPLY.
REQ-009 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-010 The LFSR SHALL be a 17-bit Fibonacci LFSR, polynomial x^17+x^14+1: next = {lfsr[15:0], lfsr[16]^lfsr[13]}.
REQ-011 The MISR SHALL be 10-bit, polynomial x^10+x^7+1: next = {misr[8:0], misr[9]^misr[6]} XOR dut_out.
REQ-012 Per-pattern latency SHALL be SETTLE+2 cycles. Start-accept to done SHALL be NUM_PATTERNS*(SETTLE+2)+1 cycles.
REQ-013 start while busy SHALL be ignored, and seed_load while busy SHALL be ignored.
REQ-014 When seed_load and start are both high in IDLE in the same cycle, the run SHALL use the old seed_reg; the new seed takes effect on the next run.
REQ-015 seed_load with seed==0 SHALL store 17'h00001 to avoid LFSR lockup.
REQ-016 On abort while busy, the FSM SHALL go to IDLE in the next cycle with no done pulse. signature and pattern_cnt SHALL hold their partial values and dut_in SHALL hold.
REQ-017 If abort and CAPTURE coincide, the capture SHALL complete first, then the FSM goes to IDLE; there SHALL be no done pulse.
REQ-018 pattern_cnt SHALL saturate at 16 bits and never wrap within a run.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state=IDLE, dut_in=0, busy=0, done=0, signature=0, pattern_cnt=0, lfsr=SEED, seed_reg=SEED.
REQ-020 Reset asserted mid-run SHALL discard the run with no done pulse. The first start after reset release SHALL behave as from power-up.

Verification
REQ-021 NUM_PATTERNS=4, SETTLE=1, seed_load 17'h00001, dut_out=0, start -> dut_in sequence 00001, 00002, 00004, 00008; signature=10'h000; done exactly 13 cycles after start is accepted; pattern_cnt=4.
REQ-022 NUM_PATTERNS=2, SETTLE=1, dut_out tied to 10'h001 -> signature 10'h001 after the first capture and 10'h003 at done.
REQ-023 seed_load with seed=0, then start -> first dut_in=17'h00001.
REQ-024 start pulsed again while busy -> no restart, and done occurs at the original cycle count.
REQ-025 abort asserted in SETTLE of pattern 3 (NUM_PATTERNS=8) -> IDLE next cycle, no done pulse, pattern_cnt=2, busy=0.
REQ-026 rst_n pulsed low mid-run -> all outputs at reset values immediately, without waiting for a clock edge; a following run with NUM_PATTERNS=4 and seed 1 matches REQ-021.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl -- logic BIST controller for a 17-input / 10-output gate model.
// An LFSR produces pseudo-random patterns. Each pattern is registered onto
// dut_in, left to settle for SETTLE cycles, and the response is then
// compacted into a MISR. A run ends after NUM_PATTERNS captures or on abort.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   start        begins a run (sampled in IDLE only)
//   abort        ends a run early; no done pulse
//   seed_load    loads seed into seed_reg (IDLE only; a zero seed is stored as 1)
//   seed         new LFSR seed
//   dut_in       registered stimulus; bit0 drives N1, bit16 drives N17
//   dut_out      response {N517..N504}; bit0 = N504
//   busy         high in every state except IDLE
//   done         one-cycle pulse at run completion
//   signature    MISR contents
//   pattern_cnt  number of patterns captured in the current or last run
module gate_bist_ctrl #(
  parameter int          NUM_PATTERNS = 256,
  parameter int          SETTLE       = 2,
  parameter logic [16:0] SEED         = 17'h1ACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        seed_load,
  input  logic [16:0] seed,
  output logic [16:0] dut_in,
  input  logic [9:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic [9:0]  signature,
  output logic [15:0] pattern_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [15:0] NP16      = 16'(NUM_PATTERNS);

  state_t      state_q, state_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [16:0] seed_reg_q, seed_reg_d;
  logic [16:0] dut_in_q, dut_in_d;
  logic [9:0]  misr_q, misr_d;
  logic [15:0] pattern_cnt_q, pattern_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0] cnt_inc;

  // Saturating increment: the count never wraps within a run.
  assign cnt_inc = (pattern_cnt_q == 16'hFFFF) ? pattern_cnt_q : pattern_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    seed_reg_d    = seed_reg_q;
    dut_in_d      = dut_in_q;
    misr_d        = misr_q;
    pattern_cnt_d = pattern_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    case (state_q)
      S_IDLE: begin
        // seed_reg updates at the same edge as start; the run below reads
        // the old seed_reg_q, so a simultaneous load only affects the next run.
        if (seed_load) seed_reg_d = (seed == 17'd0) ? 17'h00001 : seed;
        if (start) begin
          lfsr_d        = seed_reg_q;
          misr_d        = '0;
          pattern_cnt_d = '0;
          state_d       = S_APPLY;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          dut_in_d     = lfsr_q;
          settle_cnt_d = SETTLE_M1;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort)                      state_d      = S_IDLE;
        else if (settle_cnt_q == 4'd0)  state_d      = S_CAPTURE;
        else                            settle_cnt_d = settle_cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        // The capture always completes, even when abort arrives in this cycle.
        misr_d        = {misr_q[8:0], misr_q[9] ^ misr_q[6]} ^ dut_out;
        lfsr_d        = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
        pattern_cnt_d = cnt_inc;
        if (abort)                state_d = S_IDLE;
        else if (cnt_inc == NP16) state_d = S_DONE;
        else                      state_d = S_APPLY;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED;
      seed_reg_q    <= SEED;
      dut_in_q      <= '0;
      misr_q        <= '0;
      pattern_cnt_q <= '0;
      settle_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      seed_reg_q    <= seed_reg_d;
      dut_in_q      <= dut_in_d;
      misr_q        <= misr_d;
      pattern_cnt_q <= pattern_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

  assign dut_in      = dut_in_q;
  assign signature   = misr_q;
  assign pattern_cnt = pattern_cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl. A run is modelled as a timeline: cycle c after
// the start edge belongs to pattern (c-1)/(ST+2) at phase (c-1)%(ST+2),
// where phase 0 = apply, 1..ST = settle, ST+1 = capture. Done falls on cycle
// NP*(ST+2)+1. Expected dut_in and signature values come from the LFSR and
// MISR polynomials, applied once per pattern.
module tb_gate_bist_ctrl;
  localparam int          NP   = 4;
  localparam int          ST   = 1;
  localparam logic [16:0] SEED = 17'h1ACE1;

  logic        clk, rst_n, start, abort, seed_load;
  logic [16:0] seed, dut_in;
  logic [9:0]  dut_out, signature;
  logic [15:0] pattern_cnt;
  logic        busy, done;

  gate_bist_ctrl #(.NUM_PATTERNS(NP), .SETTLE(ST), .SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_load(seed_load), .seed(seed), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .signature(signature), .pattern_cnt(pattern_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] m_seed_reg;
  logic [16:0] m_dut_in;
  logic [16:0] seen_in[$];
  logic [9:0]  seen_sig[$];

  function automatic logic [16:0] lfsr_step(input logic [16:0] v);
    return {v[15:0], v[16] ^ v[13]};
  endfunction

  function automatic logic [9:0] misr_step(input logic [9:0] m, input logic [9:0] d);
    return {m[8:0], m[9] ^ m[6]} ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic load_seed(input logic [16:0] v);
    seed_load = 1'b1; seed = v;
    @(posedge clk); @(negedge clk);
    seed_load = 1'b0;
    m_seed_reg = (v == 17'd0) ? 17'h00001 : v;
  endtask

  // out_mode: 0 random dut_out, 1 all zero, 2 constant 1.
  // abort_c: cycle at which abort is raised (0 = none).
  // restart: pulse start and seed_load mid-run (both must be ignored).
  // sl_en: seed_load together with start, new seed sl_val.
  task automatic run(input int abort_c, input bit restart, input int out_mode,
                     input bit sl_en, input logic [16:0] sl_val);
    logic [16:0] lf;
    logic [9:0]  ms;
    int total, p, ph, caps;
    bit aborted;
    total = NP * (ST + 2) + 1;
    lf = m_seed_reg; ms = '0; caps = 0; aborted = 0;
    seen_in.delete(); seen_sig.delete();
    start = 1'b1;
    if (sl_en) begin seed_load = 1'b1; seed = sl_val; end
    @(posedge clk); @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    if (sl_en) m_seed_reg = (sl_val == 17'd0) ? 17'h00001 : sl_val;
    for (int c = 1; c <= total && !aborted; c++) begin
      p  = (c - 1) / (ST + 2);
      ph = (c - 1) % (ST + 2);
      chk("busy", busy, 1);
      if (c == total) begin
        chk("done_at_end", done, 1);
        chk("sig_at_done", signature, ms);
        chk("cnt_at_done", pattern_cnt, NP);
      end else begin
        chk("done_early", done, 0);
        chk("cnt_run", pattern_cnt, caps);
        if (ph == 1) begin
          chk("dut_in", dut_in, lf);
          chk("sig_run", signature, ms);
          seen_in.push_back(dut_in);
          seen_sig.push_back(signature);
        end
      end
      if (restart && c == 3) begin
        start = 1'b1; seed_load = 1'b1; seed = 17'($urandom);
      end
      case (out_mode)
        1:       dut_out = 10'h000;
        2:       dut_out = 10'h001;
        default: dut_out = 10'($urandom);
      endcase
      if (c < total) begin
        if (c == abort_c) begin abort = 1'b1; aborted = 1; end
        if (ph == 0 && !aborted) m_dut_in = lf;
        if (ph == ST + 1) begin
          ms = misr_step(ms, dut_out);
          lf = lfsr_step(lf);
          caps++;
        end
      end
      @(posedge clk); @(negedge clk);
      abort = 1'b0; start = 1'b0; seed_load = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
      chk("cnt_idle", pattern_cnt, caps);
      chk("sig_idle", signature, ms);
      chk("dut_in_idle", dut_in, m_dut_in);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sig"}, signature, 0);
    chk({tag, "_cnt"}, pattern_cnt, 0);
  endtask

  task automatic chk_req021();
    for (int i = 0; i < NP; i++) chk("seq021", seen_in[i], 17'h00001 << i);
    chk("sig021", signature, 10'h000);
    chk("cnt021", pattern_cnt, NP);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    seed = '0; dut_out = '0;
    m_seed_reg = SEED; m_dut_in = '0;
    #1;
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Power-up seed, random responses.
    run(0, 0, 0, 0, '0);
    chk("first_in_seed", seen_in[0], SEED);

    // Seed 1, zero response: walking-one stimulus, zero signature, done at 13.
    load_seed(17'h00001);
    run(0, 0, 1, 0, '0);
    chk_req021();

    // Constant response 1: signature 001 after first capture, 003 after second.
    load_seed(17'h00001);
    run(0, 0, 2, 0, '0);
    chk("sig_after1", seen_sig[1], 10'h001);
    chk("sig_after2", seen_sig[2], 10'h003);

    // Zero seed stored as 1.
    load_seed(17'h00000);
    run(0, 0, 0, 0, '0);
    chk("zero_seed_in", seen_in[0], 17'h00001);

    // start and seed_load while busy are ignored; done timing unchanged.
    run(0, 1, 0, 0, '0);

    // Abort in SETTLE of pattern 3 -> two patterns captured.
    run(2 * (ST + 2) + 2, 0, 0, 0, '0);
    chk("abort_cnt2", pattern_cnt, 2);
    // Abort coinciding with CAPTURE -> the capture completes.
    run(ST + 2, 0, 0, 0, '0);
    chk("abort_cap_cnt", pattern_cnt, 1);
    // Abort in APPLY -> dut_in holds.
    run(ST + 2 + 1, 0, 0, 0, '0);

    // seed_load together with start uses the old seed for this run.
    load_seed(17'h00001);
    run(0, 0, 0, 1, 17'h0BEEF);
    chk("old_seed_used", seen_in[0], 17'h00001);
    run(0, 0, 0, 0, '0);
    chk("new_seed_used", seen_in[0], 17'h0BEEF);

    // Randomized runs: random seeds, random abort points.
    for (int r = 0; r < 8; r++) begin
      load_seed(17'($urandom));
      run(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NP * (ST + 2))) : 0,
          0, 0, 0, '0);
    end

    // Reset mid-run: outputs drop without a clock edge.
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_seed_reg = SEED; m_dut_in = '0;
    repeat (3) begin
      chk("no_done_after_rst", done, 0);
      @(negedge clk);
    end
    load_seed(17'h00001);
    run(0, 0, 1, 0, '0);
    chk_req021();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
